// File: rtl/seq_det_param.sv
// seq_det_param: parametrised serial pattern detector with a runtime-loadable
// pattern, runtime overlap/non-overlap selection and a saturating match counter.
//
// Optional feature macro: SEQ_DET_MASK_EN adds a don't-care mask register
// (pat_mask_in, reset all ones). Without it the compare is exact.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   in           serial data bit, sampled when in_valid is high
//   in_valid     input qualifier
//   overlap      1 = overlapping detection, 0 = history restarts after a match
//   pat_load     load pat_in (and pat_mask_in) and flush the history
//   pat_in       new pattern, MSB is the first bit received
//   pat_mask_in  new mask, 0 = don't-care position (SEQ_DET_MASK_EN only)
//   cnt_clr      clear match_count (wins over a coincident match)
//   out          registered one-cycle match pulse
//   match_count  saturating count of matches
//   armed        history holds LEN valid bits
module seq_det_param #(
    parameter int unsigned      LEN     = 4,
    parameter logic [LEN-1:0]   PATTERN = LEN'(4'b1011),
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [LEN-1:0]   pat_in,
`ifdef SEQ_DET_MASK_EN
    input  logic [LEN-1:0]   pat_mask_in,
`endif
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam int unsigned FILL_W = $clog2(LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);

    logic [LEN-1:0]    pattern_q, pattern_d;
    logic [LEN-1:0]    hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              out_q, out_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              armed_q, armed_d;
`ifdef SEQ_DET_MASK_EN
    logic [LEN-1:0]    mask_q, mask_d;
`endif

    logic [LEN-1:0]    cand;
    logic [FILL_W-1:0] fill_n;
    logic              hit;
    logic              match;

    // Candidate history and match decision for the current input bit.
    always_comb begin
        cand   = {hist_q[LEN-2:0], in};
        fill_n = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
`ifdef SEQ_DET_MASK_EN
        hit    = (((cand ^ pattern_q) & mask_q) == '0);
`else
        hit    = (cand == pattern_q);
`endif
        match  = in_valid && !pat_load && (fill_n == FILL_FULL) && hit;
    end

    // Next-state for pattern, history, fill, pulse and counter.
    always_comb begin
        pattern_d = pattern_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        out_d     = 1'b0;
        cnt_d     = cnt_q;
`ifdef SEQ_DET_MASK_EN
        mask_d    = mask_q;
`endif
        if (pat_load) begin
            pattern_d = pat_in;
`ifdef SEQ_DET_MASK_EN
            mask_d    = pat_mask_in;
`endif
            hist_d    = '0;
            fill_d    = '0;
        end else if (in_valid) begin
            hist_d = cand;
            out_d  = match;
            // Non-overlap mode restarts the fill so the next match needs LEN fresh bits.
            fill_d = (match && !overlap) ? '0 : fill_n;
        end

        armed_d = (fill_d == FILL_FULL);

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pattern_q <= PATTERN;
            hist_q    <= '0;
            fill_q    <= '0;
            out_q     <= 1'b0;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
`ifdef SEQ_DET_MASK_EN
            mask_q    <= '1;
`endif
        end else begin
            pattern_q <= pattern_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
`ifdef SEQ_DET_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign out         = out_q;
    assign match_count = cnt_q;
    assign armed       = armed_q;

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
Parametrised serial pattern detector, the successor to the fixed 4-bit Mealy detector.
- Pattern width is a parameter; pattern contents are runtime-loadable.
- Overlap or non-overlap detection is chosen at runtime; input is qualified by a valid strobe.
- Keeps a saturating match counter.
- Sits on a serial bit stream (e.g. a deserialiser front end) and flags framing or sync words.

Parameters:
- LEN, 4, pattern length in bits (legal range 2..32).
- PATTERN, 4'b1011, reset value of the pattern register (LEN bits); MSB is the first bit received.
- CNT_W, 8, width of match_count.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- in  input  1  serial data bit.
- in_valid  input  1  in is sampled only when high.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- pat_load  input  1  load pat_in into the pattern register.
- pat_in  input  LEN  new pattern; MSB is the first bit received.
- cnt_clr  input  1  clear match_count.
- out  output  1  one-cycle match pulse (registered).
- match_count  output  CNT_W  saturating count of matches.
- armed  output  1  high when fill == LEN, i.e. the history is full.

Behaviour:
- Reset: clock and reset are one clock; reset is synchronous and active-low (sampled on clk rising edge while reset_n==0). On reset:
  - pattern <= PATTERN, hist <= 0, fill <= 0.
  - out <= 0, match_count <= 0, armed <= 0.
- State:
  - hist[LEN-1:0] is the shift history.
  - fill (0..LEN) is the number of valid history bits.
- Per clk with reset_n==1 and pat_load==0:
  - If in_valid==0: hist and fill hold; out <= 0.
  - If in_valid==1:
    - cand = {hist[LEN-2:0], in}.
    - fill_n = min(fill+1, LEN).
    - match = (fill_n==LEN) && (cand==pattern).
    - hist <= cand.
    - out <= match.
    - fill <= (match && !overlap) ? 0 : fill_n.
- Latency:
  - out rises on the clk edge that samples the final pattern bit; it is visible for exactly one cycle after that edge, matching the registered-Mealy timing of the predecessor.
  - Back-to-back overlapping matches give consecutive out pulses. Example: pattern 11, stream 111 gives pulses on bits 2 and 3.
- Overlap mode:
  - overlap is sampled in the cycle of the match only.
  - Changing overlap mid-stream takes effect at the next match, with no history flush.
- pat_load==1 (priority over in_valid):
  - pattern <= pat_in, hist <= 0, fill <= 0, out <= 0.
  - in is ignored that cycle.
  - match_count is not affected.
- match_count:
  - Increments by 1 on each match.
  - Saturates at 2^CNT_W-1; never wraps.
  - cnt_clr==1 forces it to 0. If cnt_clr and a match occur in the same cycle, the result is 0 (clear wins).
- armed = (fill==LEN), registered along with fill. It drops to 0 after a non-overlap match or after pat_load.
- No combinational path from any input to any output.

Optional Feature:
- Macro: SEQ_DET_MASK_EN.
- When defined:
  - Adds input port pat_mask_in[LEN-1:0], loaded together with pat_in on pat_load.
  - Reset value of the mask register is all ones.
  - Match rule becomes ((cand ^ pattern) & mask)==0; a mask bit of 0 makes that position don't-care.
  - fill must still reach LEN before any match.
- When undefined:
  - No mask port and no mask register.
  - Exact compare only; behaviour is identical to the enabled build with mask all ones.

Test Plan:
- Reset defaults, overlap=1, in_valid=1, stream 1,0,1,1,0,1,1 -> out pulses after bits 4 and 7; match_count=2.
- Same stream with overlap=0 -> single out pulse after bit 4; armed drops to 0 after the match; match_count=1.
- Stream 1,0,(in_valid=0 for 3 cycles),1,1 -> gaps are ignored; one pulse after the 4th valid bit; out=0 during the gaps.
- pat_load with pat_in=4'b0110 after bits 1,0,1 -> history flushed; stream 0,1,1,0,1,1,0 -> pulses after valid bits 4 and 7; a match spanning the load never fires.
- CNT_W=2, 5 overlapping matches of 11 on stream 111111 -> match_count sticks at 3; cnt_clr coincident with a match -> 0.
- reset_n=0 for one cycle after bits 1,0,1, then 1 -> no pulse; a full 1,0,1,1 sequence is needed after reset before any pulse. With SEQ_DET_MASK_EN, mask 4'b1101 and pattern 1011, stream 1,0,0,1 -> pulse.
